id_stage: RTL

- Instruction-decode stage of the 16-bit pipelined processor; sits directly downstream of the fetch stage and consumes its PC+1 (IF/ID) register plus the synchronous instruction-memory read data.
- Holds the 16x16 register file, resolves branches and jumps in ID, detects load-use and branch-operand hazards, and drives the fetch stage's stall, flush and redirect controls plus the halt request.
- Registers the decoded instruction into the ID/EX pipeline register.

---
 rtl/id_pkg.sv | 69 ++++++
 rtl/id_stage_if.sv | 35 +++
 rtl/id_stage_reg_file.sv | 50 +++++
 rtl/id_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg: shared definitions for the instruction-decode stage.
//   - machine widths and register count
//   - opcode constants and instruction field positions
//   - the ID/EX pipeline register layout and its bubble value
//   - a 4-bit immediate sign-extension helper
// ---------------------------------------------------------------------------
package id_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int REG_AW     = 4;
  localparam int REG_COUNT  = 1 << REG_AW;

  // Instruction field bit positions: op[15:12] rd[11:8] rs[7:4] rt[3:0]
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef struct packed {
    logic [3:0]            op;
    logic [REG_AW-1:0]     rd;
    logic [REG_AW-1:0]     rs;
    logic [REG_AW-1:0]     rt;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } idex_t;

  // A bubble is recognisable downstream by op=F with every control bit low.
  localparam idex_t IDEX_BUBBLE = '{
    op:        OP_NOP,
    rd:        '0,
    rs:        '0,
    rt:        '0,
    rs_data:   '0,
    rt_data:   '0,
    imm:       '0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

  function automatic logic [DATA_WIDTH-1:0] sext4(input logic [3:0] v);
    return {{(DATA_WIDTH-4){v[3]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if: fetch <-> decode bus.
//   Fetch drives:   running_i, instr_i (IM data), pcd_i (PC+1 of ID instr)
//   Decode drives:  stall_o, flush_o, pc_src_o/branch_addr_o,
//                   jump_o/jump_addr_o, stop_o
//   modport master = fetch side, modport slave = decode side.
// ---------------------------------------------------------------------------
interface id_stage_if;
  import id_pkg::*;

  logic                  running_i;
  logic [DATA_WIDTH-1:0] instr_i;
  logic [ADDR_WIDTH-1:0] pcd_i;

  logic                  stall_o;
  logic                  flush_o;
  logic                  pc_src_o;
  logic [ADDR_WIDTH-1:0] branch_addr_o;
  logic                  jump_o;
  logic [ADDR_WIDTH-1:0] jump_addr_o;
  logic                  stop_o;

  modport master (
    output running_i, instr_i, pcd_i,
    input  stall_o, flush_o, pc_src_o, branch_addr_o,
           jump_o, jump_addr_o, stop_o
  );

  modport slave (
    input  running_i, instr_i, pcd_i,
    output stall_o, flush_o, pc_src_o, branch_addr_o,
           jump_o, jump_addr_o, stop_o
  );

endinterface

// File: rtl/id_stage_reg_file.sv
// ---------------------------------------------------------------------------
// reg_file_16x16: 16 x 16-bit register file with two read ports.
//   clk, rst (async, active low: clears every register)
//   we_i/waddr_i/wdata_i : write port, ignored for r0
//   raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o : write-first read ports
// r0 always reads 0.
// ---------------------------------------------------------------------------
module reg_file_16x16
  import id_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_AW-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [REG_AW-1:0]     raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [REG_AW-1:0]     raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic                  wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // regs_d is the post-write view of the file, so reading it gives the
  // write-first bypass for free.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_d[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_d[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage: instruction decode stage of the 16-bit pipelined processor.
//   clk, rst          : clock, async active-low reset
//   fe (slave)        : fetch bus - instruction/PC+1 in; stall, flush,
//                       branch/jump redirects and halt request out
//   wb_*              : register-file write-back port
//   idex_*_i          : EX-stage state (this block's own ID/EX outputs)
//   exmem_*_i         : MEM-stage state, incl. ALU result
//   idex_*_o          : ID/EX pipeline register
// Optional build macro BRANCH_FWD_EN: forward the EX/MEM ALU result into
// the branch comparator instead of stalling on a MEM-stage ALU producer.
// ---------------------------------------------------------------------------
module id_stage
  import id_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  id_stage_if.slave             fe,
  input  logic                  wb_we_i,
  input  logic [REG_AW-1:0]     wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [REG_AW-1:0]     idex_rd_i,
  input  logic                  idex_reg_write_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_AW-1:0]     exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic                  exmem_mem_read_i,
  input  logic [DATA_WIDTH-1:0] exmem_alu_i,
  output logic [3:0]            idex_op_o,
  output logic [REG_AW-1:0]     idex_rd_o,
  output logic [REG_AW-1:0]     idex_rs_o,
  output logic [REG_AW-1:0]     idex_rt_o,
  output logic [DATA_WIDTH-1:0] idex_rs_data_o,
  output logic [DATA_WIDTH-1:0] idex_rt_data_o,
  output logic [DATA_WIDTH-1:0] idex_imm_o,
  output logic                  idex_reg_write_o,
  output logic                  idex_mem_read_o,
  output logic                  idex_mem_write_o
);

  logic              valid_q, valid_d;
  idex_t             idex_q, idex_d;

  logic [3:0]        op, op_live;
  logic [REG_AW-1:0] rd, rs, rt;
  logic              live;

  logic uses_rs, uses_rt, uses_rd;
  logic is_beq, is_jump, is_halt, keep;
  logic reg_write, mem_read, mem_write;

  logic [REG_AW-1:0]     raddr_b;
  logic [DATA_WIDTH-1:0] rs_val, rb_val;
  logic [DATA_WIDTH-1:0] cmp_rs, cmp_rd;

  logic load_use, beq_ex_hit, beq_mem_hit, stall, taken;

  assign op = fe.instr_i[OP_MSB:OP_LSB];
  assign rd = fe.instr_i[RD_MSB:RD_LSB];
  assign rs = fe.instr_i[RS_MSB:RS_LSB];
  assign rt = fe.instr_i[RT_MSB:RT_LSB];

  assign live    = valid_q && fe.running_i;
  assign op_live = live ? op : OP_NOP;

  // Decode: which fields are register sources, the control bits, and
  // whether the instruction itself (rather than a bubble) enters ID/EX.
  always_comb begin
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    uses_rd   = 1'b0;
    is_beq    = 1'b0;
    is_jump   = 1'b0;
    is_halt   = 1'b0;
    keep      = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (op_live)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        reg_write = 1'b1;
        keep      = 1'b1;
      end
      OP_ADDI: begin
        uses_rs   = 1'b1;
        reg_write = 1'b1;
        keep      = 1'b1;
      end
      OP_LW: begin
        uses_rs   = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        keep      = 1'b1;
      end
      OP_SW: begin
        uses_rs   = 1'b1;
        uses_rd   = 1'b1;
        mem_write = 1'b1;
        keep      = 1'b1;
      end
      OP_BEQ: begin
        uses_rs = 1'b1;
        uses_rd = 1'b1;
        is_beq  = 1'b1;
        keep    = 1'b1;
      end
      OP_J: begin
        is_jump = 1'b1;
        keep    = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // SW and BEQ read rd instead of rt, so one mux keeps the file at two
  // read ports; for SW the rd value travels down as rt_data (store data).
  assign raddr_b = uses_rd ? rd : rt;

  reg_file_16x16 u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (raddr_b),
    .rdata_b_o (rb_val)
  );

  assign load_use = idex_mem_read_i && (idex_rd_i != '0) &&
                    ((uses_rs && (idex_rd_i == rs)) ||
                     (uses_rt && (idex_rd_i == rt)) ||
                     (uses_rd && (idex_rd_i == rd)));

  assign beq_ex_hit = idex_reg_write_i &&
                      ((idex_rd_i == rd) || (idex_rd_i == rs));

`ifdef BRANCH_FWD_EN
  // Only a load in MEM still has to wait; an ALU result is forwarded.
  // r0 is never forwarded so it keeps reading as zero.
  logic fwd_rs, fwd_rd;

  assign beq_mem_hit = exmem_reg_write_i && exmem_mem_read_i &&
                       ((exmem_rd_i == rd) || (exmem_rd_i == rs));
  assign fwd_rs = exmem_reg_write_i && !exmem_mem_read_i &&
                  (exmem_rd_i != '0) && (exmem_rd_i == rs);
  assign fwd_rd = exmem_reg_write_i && !exmem_mem_read_i &&
                  (exmem_rd_i != '0) && (exmem_rd_i == rd);
  assign cmp_rs = fwd_rs ? exmem_alu_i : rs_val;
  assign cmp_rd = fwd_rd ? exmem_alu_i : rb_val;
`else
  logic unused_fwd_inputs;

  assign beq_mem_hit = exmem_reg_write_i &&
                       ((exmem_rd_i == rd) || (exmem_rd_i == rs));
  assign cmp_rs = rs_val;
  assign cmp_rd = rb_val;
  assign unused_fwd_inputs = ^{exmem_alu_i, exmem_mem_read_i};
`endif

  assign stall = load_use || (is_beq && (beq_ex_hit || beq_mem_hit));
  assign taken = is_beq && !stall && (cmp_rd == cmp_rs);

  // Redirects and halt are suppressed while stalled; the instruction is
  // re-decoded next cycle once the hazard clears.
  assign fe.stall_o       = stall;
  assign fe.pc_src_o      = taken;
  assign fe.jump_o        = is_jump && !stall;
  assign fe.flush_o       = taken || (is_jump && !stall);
  assign fe.stop_o        = is_halt && !stall;
  assign fe.branch_addr_o = fe.pcd_i + {{(ADDR_WIDTH-4){rt[3]}}, rt};
  assign fe.jump_addr_o   = fe.instr_i[ADDR_WIDTH-1:0];

  // valid_q squashes the wrong-path instruction after a redirect or halt.
  always_comb begin
    valid_d = 1'b1;
    if (fe.flush_o || fe.stop_o) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end
  end

  // ID/EX is reloaded every cycle: the decoded instruction, or a bubble
  // for stalls, HALT, NOPs and squashed slots.
  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (!stall && keep) begin
      idex_d.op        = op;
      idex_d.rd        = rd;
      idex_d.rs        = rs;
      idex_d.rt        = rt;
      idex_d.rs_data   = rs_val;
      idex_d.rt_data   = rb_val;
      idex_d.imm       = sext4(rt);
      idex_d.reg_write = reg_write;
      idex_d.mem_read  = mem_read;
      idex_d.mem_write = mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign idex_op_o        = idex_q.op;
  assign idex_rd_o        = idex_q.rd;
  assign idex_rs_o        = idex_q.rs;
  assign idex_rt_o        = idex_q.rt;
  assign idex_rs_data_o   = idex_q.rs_data;
  assign idex_rt_data_o   = idex_q.rt_data;
  assign idex_imm_o       = idex_q.imm;
  assign idex_reg_write_o = idex_q.reg_write;
  assign idex_mem_read_o  = idex_q.mem_read;
  assign idex_mem_write_o = idex_q.mem_write;

endmodule
